// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH clocks, LSB first.
// START/BUSY/DONE handshake; S/C/V registered and held between operations.
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic sum_bit;
  logic cout;

  assign sum_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign cout    = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;

    unique case (state_q)
      IDLE, FIN: begin
        if (START) begin
          state_d = RUN;
          opa_d   = A;
          opb_d   = MODE ? ~B : B;
          carry_d = MODE ? ~CIN : CIN;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB here, so it serves as cmsb directly
          state_d = FIN;
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          c_d     = cout;
          v_d     = carry_q ^ cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign S    = s_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Bench for serial_add_sub_unit: WIDTH=8 (lane 0) and WIDTH=4 (lane 1) instances checked
// every cycle against an arithmetic reference model, plus literal test-plan expectations.
module tb_serial_add_sub_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] st = '0;
  logic [1:0] md = '0;
  logic [1:0] ci = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [1:0] busy, done, cc, vv;
  logic [7:0] s8;
  logic [3:0] s4;

  int n_cmp = 0;
  int n_mis = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  serial_add_sub_unit #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST(RST), .START(st[0]), .MODE(md[0]), .CIN(ci[0]),
    .A(a8), .B(b8), .BUSY(busy[0]), .DONE(done[0]), .S(s8), .C(cc[0]), .V(vv[0])
  );

  serial_add_sub_unit #(.WIDTH(4)) u_w4 (
    .CLK(CLK), .RST(RST), .START(st[1]), .MODE(md[1]), .CIN(ci[1]),
    .A(a4), .B(b4), .BUSY(busy[1]), .DONE(done[1]), .S(s4), .C(cc[1]), .V(vv[1])
  );

  function automatic int lw(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] in_a(input int k);
    return (k == 0) ? {24'b0, a8} : {28'b0, a4};
  endfunction

  function automatic logic [31:0] in_b(input int k);
    return (k == 0) ? {24'b0, b8} : {28'b0, b4};
  endfunction

  function automatic logic [31:0] s_act(input int k);
    return (k == 0) ? {24'b0, s8} : {28'b0, s4};
  endfunction

  // Reference: plain wide addition of A + B' + cin', overflow from operand/result signs.
  function automatic logic [33:0] calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic m, input logic c);
    longint unsigned mask, aa, bb, sum;
    logic [31:0] s;
    logic co, ov, cin_eff;
    mask    = (64'd1 << w) - 64'd1;
    aa      = 64'(a);
    bb      = 64'(b);
    if (m) bb = ~bb & mask;
    cin_eff = m ? ~c : c;
    sum     = aa + bb + 64'(cin_eff);
    s       = 32'(sum & mask);
    co      = sum[w];
    ov      = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction

  int          rem   [2] = '{0, 0};
  logic        mdone [2] = '{1'b0, 1'b0};
  logic [31:0] es    [2] = '{32'h0, 32'h0};
  logic        ec    [2] = '{1'b0, 1'b0};
  logic        ev    [2] = '{1'b0, 1'b0};
  logic [33:0] pend  [2] = '{34'h0, 34'h0};

  // Model: an accepted request keeps the unit busy for WIDTH clocks, then results appear with a DONE pulse.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] <= 0; mdone[k] <= 1'b0; es[k] <= '0; ec[k] <= 1'b0; ev[k] <= 1'b0; pend[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] != 0) begin
          rem[k]   <= rem[k] - 1;
          mdone[k] <= (rem[k] == 1);
          if (rem[k] == 1) begin
            es[k] <= pend[k][31:0];
            ec[k] <= pend[k][32];
            ev[k] <= pend[k][33];
          end
        end else begin
          mdone[k] <= 1'b0;
          if (st[k]) begin
            rem[k]  <= lw(k);
            pend[k] <= calc(lw(k), in_a(k), in_b(k), md[k], ci[k]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("busy", k, 32'(busy[k]), 32'(rem[k] != 0));
        check("done", k, 32'(done[k]), 32'(mdone[k]));
        check("S",    k, s_act(k),     es[k]);
        check("C",    k, 32'(cc[k]),   32'(ec[k]));
        check("V",    k, 32'(vv[k]),   32'(ev[k]));
        check("busy_done_excl", k, 32'(busy[k] & done[k]), 32'h0);
      end
    end
  end

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic c);
    if (k == 0) begin a8 = a[7:0]; b8 = b[7:0]; end
    else        begin a4 = a[3:0]; b4 = b[3:0]; end
    md[k] = m;
    ci[k] = c;
  endtask

  // Launches an operation now (caller is off the active edge) and waits, bounded, for DONE.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic c, input logic hold,
                        output int lat, output int nbusy);
    set_ops(k, a, b, m, c);
    st[k] = 1'b1;
    lat   = 0;
    nbusy = 0;
    while (lat < 40) begin
      @(posedge CLK);
      lat++;
      #1;
      if (!hold) st[k] = 1'b0;
      if (busy[k]) nbusy++;
      if (done[k]) break;
    end
    if (!done[k]) begin
      n_cmp++;
      n_mis++;
      $display("FAIL done_timeout lane%0d: got no DONE after %0d clocks, required one", k, lat);
    end
  endtask

  task automatic lit(input string name, input int k, input logic [31:0] s, input logic c, input logic v);
    check({name, "_S"}, k, s_act(k),   s);
    check({name, "_C"}, k, 32'(cc[k]), 32'(c));
    check({name, "_V"}, k, 32'(vv[k]), 32'(v));
  endtask

  task automatic timing(input int k, input int lat, input int nbusy);
    check("latency",     k, 32'(lat),   32'(lw(k) + 1));
    check("busy_cycles", k, 32'(nbusy), 32'(lw(k)));
  endtask

  task automatic rand_lane(input int k, input int n);
    int lat, nbusy, gap;
    logic hold;
    for (int i = 0; i < n; i++) begin
      gap  = int'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0);
      if (gap > 0) begin
        st[k] = 1'b0;
        repeat (gap) @(negedge CLK);
      end
      run_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hold, lat, nbusy);
      timing(k, lat, nbusy);
    end
    st[k] = 1'b0;
  endtask

  initial begin
    int lat, nbusy;
    logic [33:0] r;

    r = calc(8, 32'h5A, 32'h33, 1'b0, 1'b0); check("model_add", 0, {30'b0, r[33:32]}, 32'h2);
    check("model_add_S", 0, r[31:0], 32'h8D);
    r = calc(8, 32'h80, 32'h01, 1'b1, 1'b0); check("model_sub", 0, {30'b0, r[33:32]}, 32'h3);
    check("model_sub_S", 0, r[31:0], 32'h7F);
    r = calc(4, 32'h7, 32'h9, 1'b0, 1'b1); check("model_w4", 1, {r[33:32], r[31:0]}, {2'b01, 32'h1});

    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, 32'(busy[k]), 32'h0);
      check("rst_done", k, 32'(done[k]), 32'h0);
      lit("rst", k, 32'h0, 1'b0, 1'b0);
    end
    RST    = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    run_op(0, 32'h5A, 32'h33, 1'b0, 1'b0, 1'b0, lat, nbusy);
    timing(0, lat, nbusy); lit("add5A33", 0, 32'h8D, 1'b0, 1'b1);
    @(negedge CLK);
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, lat, nbusy);
    lit("addFF01", 0, 32'h00, 1'b1, 1'b0);
    @(negedge CLK);
    run_op(0, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, lat, nbusy);
    lit("sub1020", 0, 32'hF0, 1'b0, 1'b0);
    run_op(0, 32'h80, 32'h01, 1'b1, 1'b0, 1'b0, lat, nbusy);
    lit("sub8001", 0, 32'h7F, 1'b1, 1'b1);
    run_op(0, 32'h05, 32'h05, 1'b1, 1'b1, 1'b0, lat, nbusy);
    lit("sub0505b", 0, 32'hFF, 1'b0, 1'b0);
    @(negedge CLK);

    // START re-pulsed and operands toggled during RUN must not disturb the result.
    set_ops(0, 32'h12, 32'h34, 1'b0, 1'b0);
    st[0] = 1'b1;
    @(posedge CLK); #1 st[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); st[0] = 1'b1; set_ops(0, 32'hFF, 32'hFF, 1'b1, 1'b1);
      @(negedge CLK); st[0] = 1'b0; set_ops(0, 32'h00, 32'h77, 1'b0, 1'b1);
    end
    lat = 0;
    while (!done[0] && lat < 20) begin @(posedge CLK); lat++; #1; end
    lit("ignore_run", 0, 32'h46, 1'b0, 1'b0);
    run_op(0, 32'h01, 32'h01, 1'b0, 1'b0, 1'b0, lat, nbusy);
    check("b2b_latency", 0, 32'(lat), 32'd9);
    lit("b2b", 0, 32'h02, 1'b0, 1'b0);
    @(negedge CLK);

    // Asynchronous reset in the middle of the 4th RUN cycle.
    set_ops(0, 32'hC3, 32'h5A, 1'b0, 1'b1);
    st[0] = 1'b1;
    @(posedge CLK); #1 st[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_busy", 0, 32'(busy[0]), 32'h0);
    check("mid_rst_done", 0, 32'(done[0]), 32'h0);
    lit("mid_rst", 0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK) RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("no_done_after_rst", 0, 32'(done[0]), 32'h0);
    end
    run_op(0, 32'h5A, 32'h33, 1'b0, 1'b0, 1'b0, lat, nbusy);
    timing(0, lat, nbusy); lit("after_rst", 0, 32'h8D, 1'b0, 1'b1);
    @(negedge CLK);

    run_op(1, 32'h7, 32'h9, 1'b0, 1'b1, 1'b0, lat, nbusy);
    timing(1, lat, nbusy); lit("w4_add", 1, 32'h1, 1'b1, 1'b0);
    @(negedge CLK);

    // START held high continuously: a new operation every WIDTH+1 clocks.
    for (int i = 0; i < 3; i++) begin
      run_op(0, 32'(8'h20 + i), 32'h11, 1'b0, 1'b0, 1'b1, lat, nbusy);
      timing(0, lat, nbusy);
      check("held_S", 0, s_act(0), 32'(8'h31 + i));
    end
    st[0] = 1'b0;
    @(negedge CLK);

    fork
      rand_lane(0, 60);
      rand_lane(1, 60);
    join
    repeat (12) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_unit.md
Name: serial_add_sub_unit

Overview:
- Parametrised bit-serial adder/subtractor; the sequential successor to the combinational half/full adder lab blocks.
- Reuses one full-adder cell over WIDTH cycles, processing one bit per clock, LSB first.
- A START/BUSY/DONE handshake launches each operation.
- Results are held in registered outputs with carry and signed-overflow flags.
- Used in the lab datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  operation request; sampled only in IDLE or DONE.
- MODE  input  1  0 = add (A+B+CIN), 1 = subtract (A-B-CIN); sampled with START.
- CIN  input  1  carry-in (add) or borrow-in (sub); sampled with START.
- A  input  WIDTH  operand A; sampled with START.
- B  input  WIDTH  operand B; sampled with START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when S/C/V are updated.
- S  output  WIDTH  registered result.
- C  output  1  carry out of the MSB; in subtract, 1 = no borrow.
- V  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - BUSY = 0, DONE = 0, S = 0, C = 0, V = 0.
  - Internal shift registers and counter = 0.
- FSM states: IDLE, RUN, FIN.
- IDLE: on an edge with START = 1, go to RUN and capture:
  - opA = A.
  - opB = MODE ? ~B : B.
  - carry = MODE ? ~CIN : CIN.
  - cnt = 0.
- RUN (BUSY = 1), each edge:
  - sum bit = opA[0] ^ opB[0] ^ carry.
  - Sum bit shifts into the MSB of the internal result register.
  - opA and opB shift right by one.
  - carry takes the full-adder carry-out.
  - The carry-in used on bit WIDTH-1 is saved as cmsb.
  - cnt increments.
  - When cnt == WIDTH-1, go to FIN on that same edge and load the outputs:
    - S = assembled result.
    - C = final carry.
    - V = cmsb ^ final carry.
- FIN (DONE = 1, exactly one cycle):
  - START = 1 launches a new operation directly into RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: START is sampled on edge E0. DONE is high during the cycle following edge E(WIDTH) (WIDTH+1 clocks after request). BUSY is high for exactly WIDTH cycles.
- START in RUN is ignored. It is not queued, and A/B/MODE/CIN changes during RUN have no effect.
- S/C/V change only on entry to FIN and hold between operations, including through IDLE.
- DONE and BUSY are never high together.
- Arithmetic: modulo 2^WIDTH. C and V follow standard ripple-carry semantics for A + (MODE ? ~B : B) + (MODE ? ~CIN : CIN).
- RST mid-operation: immediate return to the reset state. No DONE pulse, and prior results are cleared to 0.
- START held high continuously: a new operation starts every WIDTH+1 cycles.

Test Plan:
- WIDTH=8, add A=0x5A B=0x33 CIN=0, START one cycle -> BUSY 8 cycles, DONE pulse 9 clocks after request; S=0x8D C=0 V=1.
- WIDTH=8, add A=0xFF B=0x01 CIN=0 -> S=0x00 C=1 V=0. Then sub A=0x10 B=0x20 CIN=0 -> S=0xF0 C=0 (borrow) V=0.
- WIDTH=8, sub A=0x80 B=0x01 CIN=0 -> S=0x7F C=1 V=1. Sub A=0x05 B=0x05 CIN=1 -> S=0xFF C=0 V=0.
- WIDTH=8, START re-pulsed and A/B toggled during RUN -> ignored, result unchanged. START high in the FIN cycle with A=0x01 B=0x01 -> second DONE exactly 9 clocks later, S=0x02.
- WIDTH=8, RST asserted asynchronously mid-cycle on the 4th RUN cycle -> BUSY/DONE/S/C/V all 0 immediately, no DONE afterwards, FSM in IDLE. A new START then completes normally.
- WIDTH=4 build, add A=0x7 B=0x9 CIN=1 -> BUSY 4 cycles, DONE 5 clocks after request; S=0x1 C=1 V=0.
